type3_mac: RTL and testbench



---
 rtl/type3_mac_pkg.sv | 20 ++
 rtl/type3_mac_if.sv | 25 ++
 rtl/type3_mac_razor_reg.sv | 28 ++
 rtl/type3_mac.sv | 84 ++++++++
 tb/tb_type3_mac.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/type3_mac_pkg.sv
// rtl/type3_mac_pkg.sv - shared widths, types and sum helper for the type3_mac PE
`timescale 1ns/1ps
package type3_mac_pkg;

   localparam int ACT_W  = 8;
   localparam int WGT_W  = 8;
   localparam int PROD_W = 16;
   localparam int PSUM_W = 24;

   typedef logic [ACT_W-1:0]  act_t;
   typedef logic [WGT_W-1:0]  wgt_t;
   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [PSUM_W-1:0] psum_t;

   // Unsigned accumulate; the 24-bit result wraps, no saturation.
   function automatic psum_t mac_sum(psum_t ps, prod_t prod, prod_t ep);
      return ps + psum_t'(prod) + psum_t'(ep);
   endfunction

endpackage

// File: rtl/type3_mac_if.sv
// rtl/type3_mac_if.sv - data bus between a type3_mac PE and its neighbours
`timescale 1ns/1ps
interface type3_mac_if;
   import type3_mac_pkg::*;

   wgt_t  weight;
   act_t  activation;
   psum_t partial_sum_in;
   prod_t error_product_in;
   act_t  next_activation;
   psum_t partial_sum_out;
   prod_t error_product_out;
   logic  error_out;

   modport master (
      output weight, activation, partial_sum_in, error_product_in,
      input  next_activation, partial_sum_out, error_product_out, error_out
   );

   modport slave (
      input  weight, activation, partial_sum_in, error_product_in,
      output next_activation, partial_sum_out, error_product_out, error_out
   );

endinterface

// File: rtl/type3_mac_razor_reg.sv
// rtl/type3_mac_razor_reg.sv - razor_reg: rising-edge main flop, falling-edge shadow flop, mismatch flag
`timescale 1ns/1ps
module razor_reg #(
   parameter int PSUM_W = type3_mac_pkg::PSUM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PSUM_W-1:0] d,
   output logic [PSUM_W-1:0] main,
   output logic [PSUM_W-1:0] shadow,
   output logic              err
);

   // main sample taken at the rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) main <= '0;
      else        main <= d;
   end

   // shadow sample half a cycle later catches late arrivals
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) shadow <= '0;
      else        shadow <= d;
   end

   assign err = (main != shadow);

endmodule

// File: rtl/type3_mac.sv
// rtl/type3_mac.sv - error-compensating MAC PE; TYPE3_MAC_ERR_DETECT_EN enables shadow detection and product deferral
`timescale 1ns/1ps
module type3_mac
   import type3_mac_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   type3_mac_if.slave bus
);

   wgt_t  w_r;
   act_t  a_r;
   prod_t ep_r;
   psum_t ps_r;
   prod_t product;

   assign product = prod_t'(w_r) * prod_t'(a_r);

   // stage 1: capture operands and forward the activation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_r                 <= '0;
         a_r                 <= '0;
         ep_r                <= '0;
         bus.next_activation <= '0;
      end else begin
         w_r                 <= bus.weight;
         a_r                 <= bus.activation;
         ep_r                <= bus.error_product_in;
         bus.next_activation <= bus.activation;
      end
   end

`ifdef TYPE3_MAC_ERR_DETECT_EN

   psum_t ps_sh;
   logic  err;

   razor_reg #(.PSUM_W(PSUM_W)) u_razor (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (bus.partial_sum_in),
      .main   (ps_r),
      .shadow (ps_sh),
      .err    (err)
   );

   // stage 2: accumulate, or on a late partial sum take the shadow value and defer our product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.partial_sum_out   <= '0;
         bus.error_product_out <= '0;
         bus.error_out         <= 1'b0;
      end else if (err) begin
         bus.partial_sum_out   <= mac_sum(ps_sh, '0, ep_r);
         bus.error_product_out <= product;
         bus.error_out         <= 1'b1;
      end else begin
         bus.partial_sum_out   <= mac_sum(ps_r, product, ep_r);
         bus.error_product_out <= '0;
         bus.error_out         <= 1'b0;
      end
   end

`else

   // partial sum capture without a shadow sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ps_r <= '0;
      else        ps_r <= bus.partial_sum_in;
   end

   // stage 2: plain accumulate, upstream deferred product still absorbed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.partial_sum_out <= '0;
      else        bus.partial_sum_out <= mac_sum(ps_r, product, ep_r);
   end

   assign bus.error_product_out = '0;
   assign bus.error_out         = 1'b0;

`endif

endmodule

// File: tb/tb_type3_mac.sv
// tb/tb_type3_mac.sv - self-checking bench for type3_mac against an arithmetic reference model
`timescale 1ns/1ps
module tb_type3_mac;

   typedef struct packed {
      logic [23:0] psum;
      logic [15:0] epo;
      logic        err;
   } exp_t;

   typedef struct {
      logic [7:0]  w;
      logic [7:0]  a;
      logic [23:0] ps;   // value at the rising edge
      logic [23:0] sh;   // value at the following falling edge
      logic [15:0] ep;
   } smp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   type3_mac_if bus();

   type3_mac dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Result expected from one sample, straight from the arithmetic rules.
   function automatic exp_t model(smp_t s);
      exp_t r;
      longint unsigned prod;
      longint unsigned total;
      prod = longint'(s.w) * longint'(s.a);
`ifdef TYPE3_MAC_ERR_DETECT_EN
      if (s.ps != s.sh) begin
         total = longint'(s.sh) + longint'(s.ep);
         r.epo = prod[15:0];
         r.err = 1'b1;
      end else begin
         total = longint'(s.ps) + prod + longint'(s.ep);
         r.epo = 16'h0;
         r.err = 1'b0;
      end
`else
      total = longint'(s.ps) + prod + longint'(s.ep);
      r.epo = 16'h0;
      r.err = 1'b0;
`endif
      total  = total % 64'h100_0000;
      r.psum = total[23:0];
      return r;
   endfunction

   function automatic smp_t mk(logic [7:0] w, logic [7:0] a, logic [23:0] ps,
                               logic [23:0] sh, logic [15:0] ep);
      smp_t s;
      s.w = w; s.a = a; s.ps = ps; s.sh = sh; s.ep = ep;
      return s;
   endfunction

   task automatic set_in(smp_t s);
      bus.weight           = s.w;
      bus.activation       = s.a;
      bus.partial_sum_in   = s.ps;
      bus.error_product_in = s.ep;
   endtask

   // Apply one sample, optionally late-changing the partial sum, and wait for its result.
   task automatic run_one(smp_t s);
      set_in(s);
      @(posedge clk); #1;
      if (s.sh != s.ps) bus.partial_sum_in = s.sh;
      @(posedge clk);
      @(negedge clk); #1;
   endtask

   task automatic check_result(string name, smp_t s);
      exp_t e;
      exp_t got;
      e   = model(s);
      got = {bus.partial_sum_out, bus.error_product_out, bus.error_out};
      n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got psum=%h epo=%h err=%b, expected psum=%h epo=%h err=%b",
                  name, got.psum, got.epo, got.err, e.psum, e.epo, e.err);
      end
   endtask

   task automatic test_reset();
      bus.weight = 8'h0; bus.activation = 8'h0;
      bus.partial_sum_in = 24'h0; bus.error_product_in = 16'h0;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.next_activation, bus.partial_sum_out, bus.error_product_out, bus.error_out} !== 49'h0) begin
         n_fail++;
         $display("FAIL reset_state: got na=%h psum=%h epo=%h err=%b, expected all 0",
                  bus.next_activation, bus.partial_sum_out, bus.error_product_out, bus.error_out);
      end
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      smp_t s;
      s = mk(8'h10, 8'h02, 24'h004000, 24'h004000, 16'h0);
      run_one(s);
      check_result("basic_mac", s);
      n_checks++;
      if (bus.partial_sum_out !== 24'h004020) begin
         n_fail++;
         $display("FAIL basic_const: got %h expected 004020", bus.partial_sum_out);
      end
   endtask

   task automatic test_error();
      smp_t s;
      s = mk(8'h10, 8'h02, 24'h004000, 24'h008000, 16'h0);
      run_one(s);
      check_result("late_arrival", s);
   endtask

   task automatic test_ep_in();
      smp_t s;
      s = mk(8'h20, 8'h03, 24'h001000, 24'h001000, 16'h0012);
      run_one(s);
      check_result("ep_absorb", s);
      n_checks++;
      if (bus.partial_sum_out !== 24'h001072) begin
         n_fail++;
         $display("FAIL ep_const: got %h expected 001072", bus.partial_sum_out);
      end
   endtask

   task automatic test_wrap();
      smp_t s;
      s = mk(8'hFF, 8'hFF, 24'hFFFFFF, 24'hFFFFFF, 16'h0);
      run_one(s);
      n_checks++;
      if (bus.partial_sum_out !== 24'h00FE00) begin
         n_fail++;
         $display("FAIL wrap: got %h expected 00fe00", bus.partial_sum_out);
      end
      s = mk(8'hFF, 8'hFF, 24'hFFFFFF, 24'h000001, 16'hFFFF);
      run_one(s);
      check_result("wrap_error_path", s);
   endtask

   task automatic test_next_act();
      bus.activation = 8'h5A;
      @(posedge clk); #1;
      n_checks++;
      if (bus.next_activation !== 8'h5A) begin
         n_fail++;
         $display("FAIL next_act: got %h expected 5a", bus.next_activation);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_back_to_back();
      smp_t prev;
      bit   have_prev = 1'b0;
      for (int i = 0; i < 200; i++) begin
         smp_t s;
         s.w  = 8'($urandom);
         s.a  = 8'($urandom);
         s.ps = 24'($urandom);
         s.ep = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
         s.sh = s.ps;
         if ($urandom_range(0, 2) == 0) s.sh = s.ps ^ 24'($urandom_range(1, 24'hFFFFFF));
         set_in(s);
         @(posedge clk); #1;
         if (s.sh != s.ps) bus.partial_sum_in = s.sh;
         @(negedge clk); #1;
         n_checks++;
         if (bus.next_activation !== s.a) begin
            n_fail++;
            $display("FAIL stream_next_act[%0d]: got %h expected %h", i, bus.next_activation, s.a);
         end
         if (have_prev) check_result($sformatf("stream[%0d]", i - 1), prev);
         prev      = s;
         have_prev = 1'b1;
      end
      @(posedge clk);
      @(negedge clk); #1;
      check_result("stream_last", prev);
   endtask

   task automatic test_reset_mid();
      smp_t s;
      exp_t zero;
      s = mk(8'h37, 8'hC4, 24'h123456, 24'h123456, 16'h0101);
      set_in(s);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.next_activation, bus.partial_sum_out, bus.error_product_out, bus.error_out} !== 49'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got na=%h psum=%h epo=%h err=%b, expected all 0",
                  bus.next_activation, bus.partial_sum_out, bus.error_product_out, bus.error_out);
      end
      @(negedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      zero = '0;
      n_checks++;
      if ({bus.partial_sum_out, bus.error_product_out, bus.error_out} !== zero) begin
         n_fail++;
         $display("FAIL post_reset_first_edge: got psum=%h epo=%h err=%b, expected all 0",
                  bus.partial_sum_out, bus.error_product_out, bus.error_out);
      end
      @(posedge clk);
      @(negedge clk); #1;
      check_result("post_reset_result", s);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_ep_in();
      test_wrap();
      test_next_act();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
